mul_div_seq: RTL

- Iterative signed/unsigned multiply and divide unit for the next-generation ALU; replaces the combinational 8-bit array multiplier.
- Operand width is parametrised. Each operation takes one cycle per bit plus a sign-fix cycle, using a start/busy/done handshake.
- Produces the full double-width product, or quotient and remainder, with exact overflow and divide-by-zero flags.

---
 rtl/mul_div_seq_pkg.sv | 22 ++
 rtl/mul_div_seq_negate.sv | 18 +
 rtl/mul_div_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states and opcode decode helpers.
// No logic of its own.
package mul_div_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

    function automatic logic op_is_div(input logic [1:0] op_code);
        return (op_code == OP_DIV) || (op_code == OP_REM);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_code);
        return op_code != OP_MULU;
    endfunction

endpackage

// File: rtl/mul_div_seq_negate.sv
// Conditional two's-complement negator: o_out = i_neg ? -i_in : i_in.
// Purely combinational: invert-and-add-carry, like the datapath adders.
module mul_div_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_out
);

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_cin;

    assign w_inv = i_in ^ {WIDTH{i_neg}};
    assign w_cin = {{(WIDTH-1){1'b0}}, i_neg};
    assign o_out = w_inv + w_cin;

endmodule

// File: rtl/mul_div_seq.sv
// Iterative signed/unsigned multiply and divide: one magnitude step per bit, then one sign-fix cycle.
// done pulses WIDTH+1 cycles after the accept edge; start is ignored while busy and never queued.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_overflow;
    logic               r_div_zero;

    logic               w_op_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_mul_nxt;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    logic               w_sign_q;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_quo_out;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [WIDTH-1:0]   w_result_hi_nxt;
    logic               w_overflow_nxt;
    logic               w_div_zero_nxt;

    // Operand magnitudes; MULU passes raw bits, and |MIN| fits in WIDTH unsigned bits.
    assign w_op_signed = op_is_signed(op);
    assign w_neg_a     = w_op_signed & A[WIDTH-1];
    assign w_neg_b     = w_op_signed & B[WIDTH-1];

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_a (
        .i_in  (A),
        .i_neg (w_neg_a),
        .o_out (w_mag_a)
    );

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_b (
        .i_in  (B),
        .i_neg (w_neg_b),
        .o_out (w_mag_b)
    );

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_addend      = r_acc[0] ? r_mag_a : '0;
    assign w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring step on the WIDTH+1-bit partial remainder. When its top bit is set the
    // true difference still fits in WIDTH bits, so the modulo-2^WIDTH subtract is exact.
    assign w_shift             = {r_rem, r_acc[WIDTH-1]};
    assign {w_borrow, w_diff}  = {1'b0, w_shift[WIDTH-1:0]} - {1'b0, r_mag_b};
    assign w_ge                = w_shift[WIDTH] | ~w_borrow;
    assign w_rem_nxt           = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nxt           = {r_acc[WIDTH-2:0], w_ge};

    assign w_sign_q = r_sign_a ^ r_sign_b;

    mul_div_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_in  (r_acc),
        .i_neg (w_sign_q),
        .o_out (w_prod_fix)
    );

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .i_in  (r_acc[WIDTH-1:0]),
        .i_neg (w_sign_q),
        .o_out (w_quo_fix)
    );

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .i_in  (r_rem),
        .i_neg (r_sign_a),
        .o_out (w_rem_fix)
    );

    // Divide by zero leaves remainder = |A|, which the dividend-sign fix turns back into A.
    assign w_b_zero  = (r_b == '0);
    assign w_div_ovf = r_sign_a & (r_mag_a == MIN_VAL) & (&r_b);
    assign w_quo_out = w_b_zero ? '1 : w_quo_fix;

    always_comb begin
        w_result_nxt    = '0;
        w_result_hi_nxt = '0;
        w_overflow_nxt  = 1'b0;
        w_div_zero_nxt  = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_result_nxt    = w_prod_fix[WIDTH-1:0];
                w_result_hi_nxt = w_prod_fix[2*WIDTH-1:WIDTH];
                w_overflow_nxt  = w_prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_fix[WIDTH-1]}};
            end
            OP_MULU: begin
                w_result_nxt    = w_prod_fix[WIDTH-1:0];
                w_result_hi_nxt = w_prod_fix[2*WIDTH-1:WIDTH];
                w_overflow_nxt  = w_prod_fix[2*WIDTH-1:WIDTH] != '0;
            end
            OP_DIV: begin
                w_result_nxt    = w_quo_out;
                w_result_hi_nxt = w_rem_fix;
                w_overflow_nxt  = ~w_b_zero & w_div_ovf;
                w_div_zero_nxt  = w_b_zero;
            end
            default: begin
                w_result_nxt    = w_rem_fix;
                w_result_hi_nxt = w_quo_out;
                w_overflow_nxt  = ~w_b_zero & w_div_ovf;
                w_div_zero_nxt  = w_b_zero;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_b         <= '0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_overflow  <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= CALC;
                        r_cnt    <= '0;
                        r_op     <= op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_b      <= B;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_rem    <= '0;
                        r_acc    <= op_is_div(op) ? {{WIDTH{1'b0}}, w_mag_a}
                                                  : {{WIDTH{1'b0}}, w_mag_b};
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (op_is_div(r_op)) begin
                        r_acc[WIDTH-1:0] <= w_quo_nxt;
                        r_rem            <= w_rem_nxt;
                    end else begin
                        r_acc <= w_acc_mul_nxt;
                    end
                    if (r_cnt == LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state     <= IDLE;
                    r_done      <= 1'b1;
                    r_result    <= w_result_nxt;
                    r_result_hi <= w_result_hi_nxt;
                    r_overflow  <= w_overflow_nxt;
                    r_div_zero  <= w_div_zero_nxt;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign overflow  = r_overflow;
    assign div_zero  = r_div_zero;

endmodule
